// File: rtl/dump_pkg.sv
// Shared definitions for the capture-RAM dump controller: FSM states,
// dump length, EEPROM slave select and the EEPROM read command format.
package dump_pkg;

   // Dump sequencer states, in the order a dump walks through them.
   typedef enum logic [3:0] {
      IDLE,
      OFF_CMD,
      OFF_RD,
      GAIN_CMD,
      GAIN_RD,
      RAM_RD,
      SEND,
      WAIT_TX,
      DONE
   } state_t;

   localparam int         NUM_SAMPLES = 512;
   localparam logic [8:0] LAST_IDX    = 9'(NUM_SAMPLES - 1);
   localparam logic [2:0] SS_EEP      = 3'b100;
   localparam logic [2:0] SS_NONE     = 3'b000;
   localparam logic [1:0] EEP_RD      = 2'b00;
   localparam logic [1:0] CH_RSVD     = 2'b11;

   // EEPROM read command: opcode, 6-bit calibration address
   // {channel, gain setting, offset(0)/gain(1)}, then a don't-care byte.
   function automatic logic [15:0] eep_rd_word(input logic [1:0] ch,
                                               input logic [2:0] gain,
                                               input logic       is_gain);
      return {EEP_RD, ch, gain, is_gain, 8'h00};
   endfunction

endpackage

// File: rtl/dump_ctrl_if.sv
// Signal bundle between the dump controller and its neighbours
// (command decoder, SPI master, capture RAM, UART transmitter).
//
// Handshake semantics: there is no valid/ready pairing on this bus. Every
// control signal is a single-cycle pulse sampled on the rising clock edge:
// dump starts a dump (with dump_ch/start_addr valid in the same cycle),
// wrt_SPI starts one SPI transfer that SPI_done later closes, send_resp
// starts one UART byte that resp_sent later closes. A closing pulse is
// only honoured while the controller is waiting for it.
interface dump_ctrl_if;

   logic        dump;
   logic [1:0]  dump_ch;
   logic [2:0]  ch1_AFEgain;
   logic [2:0]  ch2_AFEgain;
   logic [2:0]  ch3_AFEgain;
   logic [8:0]  start_addr;
   logic        SPI_done;
   logic        resp_sent;

   logic        wrt_SPI;
   logic [15:0] SPI_data;
   logic [2:0]  ss;
   logic        flopOffset;
   logic        flopGain;
   logic [8:0]  ram_addr;
   logic        ram_re;
   logic        send_resp;
   logic        busy;
   logic        dump_done;

   // Controller side.
   modport master (
      input  dump, dump_ch, ch1_AFEgain, ch2_AFEgain, ch3_AFEgain,
             start_addr, SPI_done, resp_sent,
      output wrt_SPI, SPI_data, ss, flopOffset, flopGain, ram_addr,
             ram_re, send_resp, busy, dump_done
   );

   // Environment side.
   modport slave (
      output dump, dump_ch, ch1_AFEgain, ch2_AFEgain, ch3_AFEgain,
             start_addr, SPI_done, resp_sent,
      input  wrt_SPI, SPI_data, ss, flopOffset, flopGain, ram_addr,
             ram_re, send_resp, busy, dump_done
   );

endinterface

// File: rtl/dump_ctrl.sv
// Dump controller: reads the offset and gain calibration words for the
// selected channel from the EEPROM over SPI, then streams all 512 captured
// samples from the circular capture RAM, oldest first, to the UART.
module dump_ctrl
   import dump_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   dump_ctrl_if.master bus,
   output state_t      state_o
);

   state_t      state_q;
   logic [8:0]  rd_ptr_q;
   logic [8:0]  count_q;
   logic [1:0]  ch_q;
   logic [2:0]  gain_q;
   logic        wrt_spi_q;
   logic [15:0] spi_data_q;
   logic        flop_off_q;
   logic        flop_gain_q;
   logic        ram_re_q;
   logic        send_resp_q;
   logic        busy_q;
   logic        dump_done_q;
   logic [2:0]  gain_pick;

   // Analog gain of the channel being requested, captured at accept.
   always_comb begin
      case (bus.dump_ch)
         2'b01:   gain_pick = bus.ch2_AFEgain;
         2'b10:   gain_pick = bus.ch3_AFEgain;
         default: gain_pick = bus.ch1_AFEgain;
      endcase
   end

   // Dump sequencer; every output is a register set on the edge that
   // enters the state in which it must be seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rd_ptr_q    <= 9'd0;
         count_q     <= 9'd0;
         ch_q        <= 2'd0;
         gain_q      <= 3'd0;
         wrt_spi_q   <= 1'b0;
         spi_data_q  <= 16'h0000;
         flop_off_q  <= 1'b0;
         flop_gain_q <= 1'b0;
         ram_re_q    <= 1'b0;
         send_resp_q <= 1'b0;
         busy_q      <= 1'b0;
         dump_done_q <= 1'b0;
      end else begin
         // Pulses last one cycle unless a transition re-asserts them.
         wrt_spi_q   <= 1'b0;
         spi_data_q  <= 16'h0000;
         flop_off_q  <= 1'b0;
         flop_gain_q <= 1'b0;
         ram_re_q    <= 1'b0;
         send_resp_q <= 1'b0;
         dump_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.dump && (bus.dump_ch != CH_RSVD)) begin
                  ch_q       <= bus.dump_ch;
                  gain_q     <= gain_pick;
                  rd_ptr_q   <= bus.start_addr;
                  count_q    <= 9'd0;
                  wrt_spi_q  <= 1'b1;
                  spi_data_q <= eep_rd_word(bus.dump_ch, gain_pick, 1'b0);
                  busy_q     <= 1'b1;
                  state_q    <= OFF_CMD;
               end
            end
            OFF_CMD: begin
               // Command accepted; clock out the offset word.
               if (bus.SPI_done) begin
                  wrt_spi_q <= 1'b1;
                  state_q   <= OFF_RD;
               end
            end
            OFF_RD: begin
               // Offset word is on EEP_data; capture it and ask for gain.
               if (bus.SPI_done) begin
                  flop_off_q <= 1'b1;
                  wrt_spi_q  <= 1'b1;
                  spi_data_q <= eep_rd_word(ch_q, gain_q, 1'b1);
                  state_q    <= GAIN_CMD;
               end
            end
            GAIN_CMD: begin
               if (bus.SPI_done) begin
                  wrt_spi_q <= 1'b1;
                  state_q   <= GAIN_RD;
               end
            end
            GAIN_RD: begin
               if (bus.SPI_done) begin
                  flop_gain_q <= 1'b1;
                  ram_re_q    <= 1'b1;
                  state_q     <= RAM_RD;
               end
            end
            RAM_RD: begin
               // RAM data arrives one cycle after ram_re, in SEND.
               send_resp_q <= 1'b1;
               state_q     <= SEND;
            end
            SEND: begin
               state_q <= WAIT_TX;
            end
            WAIT_TX: begin
               if (bus.resp_sent) begin
                  rd_ptr_q <= rd_ptr_q + 9'd1;
                  count_q  <= count_q + 9'd1;
                  if (count_q == LAST_IDX) begin
                     busy_q      <= 1'b0;
                     dump_done_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     ram_re_q <= 1'b1;
                     state_q  <= RAM_RD;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.wrt_SPI    = wrt_spi_q;
   assign bus.SPI_data   = spi_data_q;
   assign bus.ss         = busy_q ? SS_EEP : SS_NONE;
   assign bus.flopOffset = flop_off_q;
   assign bus.flopGain   = flop_gain_q;
   assign bus.ram_addr   = rd_ptr_q;
   assign bus.ram_re     = ram_re_q;
   assign bus.send_resp  = send_resp_q;
   assign bus.busy       = busy_q;
   assign bus.dump_done  = dump_done_q;
   assign state_o        = state_q;

endmodule
